// File: rtl/sigmoid_result_packer.sv
// sigmoid_result_packer: credit-gated element FIFO packing bf16 results into LANES-wide words.
// Define SIGMOID_PACK_FLUSH_EN to add flush_i / out_mask_o partial-word flush.
module sigmoid_result_packer #(
  parameter int LANES      = 4,
  parameter int DEPTH      = 8,
  parameter int INFLIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_i,
  output logic                  issue_ready_o,
  input  logic                  res_valid_i,
  input  logic [15:0]           res_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [16*LANES-1:0]   out_data_o,
  output logic [1:0]            err_o
`ifdef SIGMOID_PACK_FLUSH_EN
  ,
  input  logic                  flush_i,
  output logic [LANES-1:0]      out_mask_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = ((CW > INFLIGHT_W) ? CW : INFLIGHT_W) + 1;

  logic [15:0]           mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         count;
  logic [INFLIGHT_W-1:0] inflight;

  logic [SW-1:0]         occ;
  logic                  full;
  logic                  wr_en;
  logic                  out_free;
  logic                  pop_full;
  logic                  pop_part;
  logic                  pop;
  logic                  proto_err;
  logic                  ovf_err;
  logic [CW-1:0]         pop_n;
  logic [16*LANES-1:0]   pack_data;

  // Credit counts both buffered and still-in-pipeline elements.
  assign occ           = SW'(count) + SW'(inflight);
  assign issue_ready_o = occ < SW'(DEPTH);

  assign full      = count == CW'(DEPTH);
  assign wr_en     = res_valid_i && !full;
  assign ovf_err   = res_valid_i && full;
  assign out_free  = !out_valid_o || out_ready_i;
  assign pop_full  = (count >= CW'(LANES)) && out_free;
  assign proto_err = (issue_i && !issue_ready_o) ||
                     (res_valid_i && inflight == '0);

`ifdef SIGMOID_PACK_FLUSH_EN
  logic                  flush_pend;
  logic                  flush_req;
  logic                  flush_done;
  logic [LANES-1:0]      pack_mask;

  assign flush_req  = flush_pend || flush_i;
  assign pop_part   = flush_req && inflight == '0 &&
                      count != '0 && count < CW'(LANES) && out_free;
  assign flush_done = flush_req && inflight == '0 &&
                      (count == '0 || pop_part);

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (flush_done) begin
      flush_pend <= 1'b0;
    end else if (flush_i) begin
      flush_pend <= 1'b1;
    end
  end
`else
  assign pop_part = 1'b0;
`endif

  assign pop = pop_full || pop_part;

  always_comb begin
    pop_n = '0;
    if (pop_full) begin
      pop_n = CW'(LANES);
    end else if (pop_part) begin
      pop_n = count;
    end
  end

  // Lanes beyond pop_n (partial flush only) are zero-filled.
  always_comb begin
    pack_data = '0;
`ifdef SIGMOID_PACK_FLUSH_EN
    pack_mask = '0;
`endif
    for (int k = 0; k < LANES; k++) begin
      if (CW'(k) < pop_n) begin
        pack_data[16*k +: 16] = mem[rptr + AW'(k)];
`ifdef SIGMOID_PACK_FLUSH_EN
        pack_mask[k] = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= res_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      inflight <= '0;
      err_o    <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      rptr  <= rptr + AW'(pop_n);
      count <= count + CW'(wr_en) - pop_n;
      unique case (1'b1)
        (issue_i && !res_valid_i): inflight <= inflight + 1'b1;
        (res_valid_i && !issue_i): begin
          if (inflight != '0) begin
            inflight <= inflight - 1'b1;
          end
        end
        default: ;
      endcase
      err_o <= err_o | {proto_err, ovf_err};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (pop) begin
      out_valid_o <= 1'b1;
      out_data_o  <= pack_data;
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

`ifdef SIGMOID_PACK_FLUSH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_mask_o <= '0;
    end else if (pop) begin
      out_mask_o <= pack_mask;
    end
  end
`endif

endmodule

// File: tb/tb_sigmoid_result_packer.sv
// tb_sigmoid_result_packer: randomized stream with a fixed-latency upstream model,
// queue-based word reference and a decoupled output monitor.
module tb_sigmoid_result_packer;

  localparam int LANES      = 4;
  localparam int DEPTH      = 8;
  localparam int INFLIGHT_W = 4;
  localparam int LAT        = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_i = 1'b0;
  logic        issue_ready_o;
  logic        res_valid_i = 1'b0;
  logic [15:0] res_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [63:0] out_data_o;
  logic [1:0]  err_o;
`ifdef SIGMOID_PACK_FLUSH_EN
  logic        flush_i = 1'b0;
  logic [3:0]  out_mask_o;
`endif

  sigmoid_result_packer #(
    .LANES(LANES), .DEPTH(DEPTH), .INFLIGHT_W(INFLIGHT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .issue_i(issue_i),
    .issue_ready_o(issue_ready_o),
    .res_valid_i(res_valid_i),
    .res_data_i(res_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o(out_data_o),
    .err_o(err_o)
`ifdef SIGMOID_PACK_FLUSH_EN
    ,
    .flush_i(flush_i),
    .out_mask_o(out_mask_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int words  = 0;
  int issued = 0;
  bit sb_on  = 1'b1;

  logic [15:0] elems[$];
  logic [63:0] exp_q[$];
  bit          pipe_v[LAT];
  logic [15:0] pipe_d[LAT];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: every LANES accepted results form one word, oldest in lane 0.
  task automatic push_elem(input logic [15:0] d);
    logic [63:0] w;
    elems.push_back(d);
    if (elems.size() == LANES) begin
      w = '0;
      for (int k = 0; k < LANES; k++) w[16*k +: 16] = elems[k];
      exp_q.push_back(w);
      elems.delete();
    end
  endtask

  task automatic clear_model();
    elems.delete();
    exp_q.delete();
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    issued = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of the upstream model: credit-gated issue, fixed latency return.
  task automatic step(input bit want, input logic [15:0] d);
    issue_i     = want && issue_ready_o;
    res_valid_i = pipe_v[LAT-1];
    res_data_i  = pipe_d[LAT-1];
    if (res_valid_i) push_elem(res_data_i);
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0] = issue_i;
    pipe_d[0] = d;
    if (issue_i) issued++;
    tick();
  endtask

  function automatic bit pipe_busy();
    bit b;
    b = 1'b0;
    for (int i = 0; i < LAT; i++) b |= pipe_v[i];
    return b;
  endfunction

  task automatic top_up_and_drain(input string name);
    int n;
    n = 0;
    while ((issued % LANES) != 0 && n < 100) begin
      step(1'b1, 16'($urandom));
      n++;
    end
    out_ready_i = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || pipe_busy() || elems.size() != 0) && n < 300) begin
      step(1'b0, '0);
      n++;
    end
    issue_i = 1'b0;
    res_valid_i = 1'b0;
    tick();
    tick();
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_err"}, 64'(err_o), 64'd0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_valid"}, 64'(out_valid_o), 64'd0);
    chk({name, "_data"}, out_data_o, 64'd0);
    chk({name, "_err"}, 64'(err_o), 64'd0);
    chk({name, "_ready"}, 64'(issue_ready_o), 64'd1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold stability.
  bit          stall = 1'b0;
  logic [63:0] held = '0;
  always @(negedge clk) begin
    if (rst || !sb_on) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", 64'(out_valid_o), 64'd1);
        chk("hold_data", out_data_o, held);
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", out_data_o);
        end else begin
          chk("word", out_data_o, exp_q.pop_front());
        end
        words++;
      end
      stall = out_valid_o && !out_ready_i;
      held  = out_data_o;
    end
  end

  logic [15:0] dir_v [4];
  int          w0;

  initial begin
    dir_v[0] = 16'h3F00; dir_v[1] = 16'h3F3B;
    dir_v[2] = 16'h3F62; dir_v[3] = 16'h3F74;
    clear_model();
    rst = 1'b1;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;

    // Directed four-result word and one-cycle latency.
    issue_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      issue_i     = (i < 3);
      res_valid_i = 1'b1;
      res_data_i  = dir_v[i];
      push_elem(dir_v[i]);
      tick();
    end
    res_valid_i = 1'b0;
    issue_i     = 1'b0;
    chk("lat_not_yet", 64'(out_valid_o), 64'd0);
    tick();
    chk("lat_valid", 64'(out_valid_o), 64'd1);
    chk("dir_data", out_data_o, 64'h3F74_3F62_3F3B_3F00);
    chk("dir_err", 64'(err_o), 64'd0);
    tick();
    tick();

    // Backpressure: credit exhausted after eight issues, first word holds.
    out_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue_i = 1'b1;
      tick();
    end
    issue_i = 1'b0;
    chk("credit_low", 64'(issue_ready_o), 64'd0);
    for (int i = 0; i < 8; i++) begin
      res_valid_i = 1'b1;
      res_data_i  = 16'($urandom);
      push_elem(res_data_i);
      tick();
    end
    res_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_hold_valid", 64'(out_valid_o), 64'd1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_drained", 64'(out_valid_o), 64'd0);
    chk("bp_credit", 64'(issue_ready_o), 64'd1);
    chk("bp_err", 64'(err_o), 64'd0);

    // Same-cycle issue and result: twenty results, five words.
    w0 = words;
    issue_i = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      issue_i     = (i < 19);
      res_valid_i = 1'b1;
      res_data_i  = 16'($urandom);
      push_elem(res_data_i);
      tick();
      if (i < 19) chk("same_credit", 64'(issue_ready_o), 64'd1);
    end
    issue_i = 1'b0;
    res_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("same_words", 64'(words - w0), 64'd5);
    chk("same_err", 64'(err_o), 64'd0);

    // Random stream, ready toggling every cycle, then random ready.
    clear_model();
    for (int i = 0; i < 400; i++) begin
      out_ready_i = ~out_ready_i;
      step(($urandom % 100) < 75, 16'($urandom));
    end
    for (int i = 0; i < 400; i++) begin
      out_ready_i = ($urandom % 100) < 40;
      step(($urandom % 100) < 80, 16'($urandom));
    end
    top_up_and_drain("rand");

    // Error flags: result without credit, then FIFO overflow.
    sb_on = 1'b0;
    res_valid_i = 1'b1;
    res_data_i  = 16'h1234;
    tick();
    res_valid_i = 1'b0;
    tick();
    chk("err_proto", 64'(err_o), 64'b10);
    out_ready_i = 1'b0;
    res_valid_i = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    res_valid_i = 1'b0;
    tick();
    chk("err_ovf", 64'(err_o), 64'b11);
    tick();
    tick();
    chk("err_sticky", 64'(err_o), 64'b11);
    rst = 1'b1;
    tick();
    check_reset("reset2");
    rst = 1'b0;
    clear_model();
    sb_on = 1'b1;

    // Reset in the middle of a stream.
    for (int i = 0; i < 40; i++) begin
      out_ready_i = ($urandom % 100) < 50;
      step(1'b1, 16'($urandom));
    end
    rst = 1'b1;
    issue_i = 1'b0;
    res_valid_i = 1'b0;
    tick();
    check_reset("reset_mid");
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 80; i++) begin
      out_ready_i = ($urandom % 100) < 60;
      step(($urandom % 100) < 70, 16'($urandom));
    end
    top_up_and_drain("recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigmoid_result_packer.md
Name: sigmoid_result_packer

Overview:
Downstream consumer of the bf16 sigmoid pipeline, which has no backpressure.
- Captures each valid bf16 result into an element FIFO.
- Packs LANES consecutive results into one wide word and presents it on a valid/ready output.
- Gives the upstream issuer a credit signal, so a value is launched into the sigmoid pipeline only when a FIFO slot is guaranteed. No result is ever dropped.

Parameters:
LANES, 4, bf16 results per output word (power of two, >=1)
DEPTH, 8, element FIFO capacity in bf16 entries (>= LANES, power of two)
INFLIGHT_W, 4, width of in-flight counter (must hold DEPTH)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
issue_i  input  1  pulse: upstream launched one element into the sigmoid pipeline this cycle
issue_ready_o  output  1  credit available; upstream may assert issue_i only when high
res_valid_i  input  1  sigmoid pipeline valid_out
res_data_i  input  16  sigmoid pipeline data_out (bf16)
out_valid_o  output  1  packed word valid
out_ready_i  input  1  downstream accepts word
out_data_o  output  16*LANES  packed word; lane k in bits [16k+15:16k], lane 0 = oldest result
err_o  output  2  sticky: bit0 overflow (write while FIFO full), bit1 protocol (issue without credit, or result with inflight==0)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values:
  - out_valid_o=0, out_data_o=0, err_o=0.
  - FIFO count=0, read/write pointers=0, inflight=0.
  - issue_ready_o=1.
- Reset mid-operation discards all buffered elements, the held output word and all credits. The sigmoid pipeline shares rst, so no stale results return.
- Credit:
  - issue_ready_o = (count + inflight) < DEPTH, combinational from registers only. It does not depend on issue_i or res_valid_i in the same cycle.
  - inflight: +1 on issue_i, -1 on res_valid_i, unchanged when both occur in the same cycle.
  - Saturates at 0 on a protocol-error decrement.
- FIFO write:
  - On a clk edge with res_valid_i=1, res_data_i is written at wptr; wptr wraps modulo DEPTH and count increments.
  - If count==DEPTH, the data is discarded and err_o[0] is set; count is unchanged.
- Pack/pop:
  - At an edge where count>=LANES and (out_valid_o==0 or out_ready_i==1), LANES entries are popped oldest-first into out_data_o, out_valid_o<=1 and rptr advances by LANES (wrap).
  - Else, if out_valid_o && out_ready_i, then out_valid_o<=0.
  - Pop and write in the same edge are both performed: count_next = count + write - LANES*pop. A pop decision uses the registered count only; the element written at that same edge is not counted.
- Latency: the LANES-th result sampled at edge N gives out_valid_o=1 after edge N+1.
- Output stability: out_data_o and out_valid_o are held constant while out_valid_o && !out_ready_i.
- Throughput: one word per LANES cycles sustained with out_ready_i tied high.
- Remainder: fewer than LANES elements stay buffered indefinitely. The partial flush described under Optional Feature is the only exception.
- err_o bits are sticky until rst.

Optional Feature:
Macro: SIGMOID_PACK_FLUSH_EN.
- Defined: adds ports flush_i (input, 1) and out_mask_o (output, LANES).
  - A flush_i pulse arms a flush request that completes when inflight==0, 0<count<LANES and the output register is free.
  - At that point all count entries are popped into the low lanes. Unused lanes are 16'h0000, out_mask_o has ones for the valid lanes, and the request clears.
  - A flush with count==0 and inflight==0 clears immediately, with no output.
  - Full words always set out_mask_o to all ones.
- Undefined: neither port exists; behaviour is as in Behaviour.

Test Plan:
- Reset, then 4 results 3F00,3F3B,3F62,3F74 on consecutive cycles (each preceded by issue_i) -> one cycle after the 4th, out_valid_o=1, out_data_o=3F74_3F62_3F3B_3F00, err_o=0.
- Issue 8 elements back-to-back with out_ready_i=0 -> issue_ready_o low after the 8th issue. Results return, 2 words are produced, the first holds; raising out_ready_i restores credit, with no overflow.
- Same-cycle issue_i and res_valid_i for 20 cycles with out_ready_i=1 -> inflight constant, 5 words emitted in order, FIFO pointers wrap correctly.
- out_ready_i toggling every other cycle during streaming -> out_data_o stable while stalled, no word lost or duplicated (scoreboard).
- Force res_valid_i with inflight==0 -> err_o[1]=1. Fill the FIFO and force an extra write -> err_o[0]=1. Assert rst mid-stream -> all outputs return to reset values on the next cycle.
- (SIGMOID_PACK_FLUSH_EN) 3 results then flush_i -> out_data_o=0000_x2_x1_x0, out_mask_o=4'b0111.
